multi_tap_delay: RTL and testbench

MULTI_TAP_DELAY -- requirements
Module: multi_tap_delay

---
 rtl/mtd_pkg.sv | 25 ++
 rtl/mtd_channel.sv | 112 +++++++++++
 rtl/multi_tap_delay.sv | 47 ++++
 tb/tb_multi_tap_delay.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtd_pkg.sv
// Shared constants, sample type and width helper for the multi-tap delay line.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mtd_pkg;

    localparam int MTD_N_CH  = 4;
    localparam int MTD_DW    = 13;
    localparam int MTD_DEPTH = 32;

    typedef logic signed [MTD_DW-1:0] sample_t;

    // Number of address bits needed to index 'value' distinct entries.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mtd_channel.sv
// One delay channel: shift storage, tap clamp/error, fill counter, registered output.
// Latency: tap_q ce-samples of delay plus one clk output register.
// Backpressure: none; ce is a sample strobe, nothing shifts or updates while it is low.
module mtd_channel
    import mtd_pkg::*;
#(
    parameter int             DW    = MTD_DW,
    parameter int             DEPTH = MTD_DEPTH,
    parameter logic [DW-1:0]  INIT  = '0,
    localparam int            TAP_W = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ce,
    input  logic signed [DW-1:0] i_din,
    input  logic [TAP_W-1:0]     i_tap,
    input  logic                 i_bypass,
    input  logic                 i_err_clr,
    output logic signed [DW-1:0] o_dout,
    output logic                 o_dout_valid,
    output logic                 o_tap_err
);

    // Storage holds DEPTH-1 past samples; the current din covers a delay of zero.
    localparam int             SR_N     = DEPTH - 1;
    localparam int             SR_AW    = (SR_N > 1) ? clog2(SR_N) : 1;
    localparam logic [TAP_W:0] TAP_MAX  = (TAP_W+1)'(DEPTH - 1);
    localparam logic [TAP_W:0] FILL_MAX = (TAP_W+1)'(DEPTH);

    logic signed [DW-1:0] r_sr [SR_N];
    logic [TAP_W-1:0]     r_tap_q;
    logic                 r_byp_q;
    logic [TAP_W:0]       r_fill;
    logic                 r_tap_err;
    logic signed [DW-1:0] r_dout;
    logic                 r_dout_valid;

    logic                 w_tap_over;
    logic [TAP_W-1:0]     w_tap_clamp;
    logic [SR_AW-1:0]     w_rd_addr;
    logic signed [DW-1:0] w_sel_dat;
    logic                 w_vld_n;
    logic signed [DW-1:0] w_dout_n;

    // Non-power-of-two depths leave tap codes above DEPTH-1 that must be clamped.
    assign w_tap_over  = {1'b0, i_tap} > TAP_MAX;
    assign w_tap_clamp = w_tap_over ? TAP_MAX[TAP_W-1:0] : i_tap;

    // Entry k of storage holds the sample accepted k+1 strobes ago.
    assign w_rd_addr = SR_AW'(r_tap_q - TAP_W'(1));
    assign w_sel_dat = (r_byp_q || (r_tap_q == '0)) ? i_din : r_sr[w_rd_addr];
    assign w_vld_n   = r_byp_q || (r_fill >= {1'b0, r_tap_q});

`ifdef MTD_INVALID_ZERO_EN
    assign w_dout_n = w_vld_n ? w_sel_dat : '0;
`else
    assign w_dout_n = w_sel_dat;
`endif

    // Shift array: plain data movement only, so it maps onto shift-register primitives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SR_N; i++) begin
                r_sr[i] <= INIT;
            end
        end else if (i_ce) begin
            r_sr[0] <= i_din;
            for (int i = 1; i < SR_N; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    // Tap/bypass capture every clk; out-of-range error is sticky and set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tap_q   <= '0;
            r_byp_q   <= 1'b0;
            r_tap_err <= 1'b0;
        end else begin
            r_tap_q <= w_tap_clamp;
            r_byp_q <= i_bypass;
            if (w_tap_over) begin
                r_tap_err <= 1'b1;
            end else if (i_err_clr) begin
                r_tap_err <= 1'b0;
            end
        end
    end

    // Output update and fill count on each strobe; valid is a one-clk pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= INIT;
            r_dout_valid <= 1'b0;
            r_fill       <= '0;
        end else if (i_ce) begin
            r_dout       <= w_dout_n;
            r_dout_valid <= w_vld_n;
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + (TAP_W+1)'(1);
            end
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_tap_err    = r_tap_err;

endmodule

// File: rtl/multi_tap_delay.sv
// N_CH independent programmable delay lines sharing one sample strobe; MTD_INVALID_ZERO_EN zeroes invalid outputs.
// Latency: per channel, tap ce-samples plus one clk register; tap/bypass changes act one clk later.
// Backpressure: none; the block accepts a sample on every ce and never stalls.
module multi_tap_delay
    import mtd_pkg::*;
#(
    parameter int  N_CH  = MTD_N_CH,
    parameter int  DW    = MTD_DW,
    parameter int  DEPTH = MTD_DEPTH,
    parameter int  INIT  = 0,
    localparam int TAP_W = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [N_CH*DW-1:0]    din,
    input  logic [N_CH*TAP_W-1:0] tap,
    input  logic [N_CH-1:0]       bypass,
    input  logic                  err_clr,
    output logic [N_CH*DW-1:0]    dout,
    output logic [N_CH-1:0]       dout_valid,
    output logic [N_CH-1:0]       tap_err
);

    localparam logic [DW-1:0] INIT_S = DW'(INIT);

    // One fully independent channel per lane; only clk, rst, ce and err_clr are shared.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        mtd_channel #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .INIT  (INIT_S)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_ce         (ce),
            .i_din        (din[c*DW +: DW]),
            .i_tap        (tap[c*TAP_W +: TAP_W]),
            .i_bypass     (bypass[c]),
            .i_err_clr    (err_clr),
            .o_dout       (dout[c*DW +: DW]),
            .o_dout_valid (dout_valid[c]),
            .o_tap_err    (tap_err[c])
        );
    end

endmodule

// File: tb/tb_multi_tap_delay.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based history model.
// Latency: model predicts outputs one clk after each edge's inputs.
// Backpressure: n/a.
module tb_multi_tap_delay;
    import mtd_pkg::*;

    localparam int N_CH  = 4;
    localparam int DW    = 13;
    localparam int DEPTH = 24;
    localparam int INIT  = 100;
    localparam int TAP_W = clog2(DEPTH);
    localparam logic [DW-1:0] INIT_S = DW'(INIT);

    logic                  clk     = 1'b0;
    logic                  rst     = 1'b0;
    logic                  ce      = 1'b0;
    logic                  err_clr = 1'b0;
    logic [N_CH*DW-1:0]    din     = '0;
    logic [N_CH*TAP_W-1:0] tap     = '0;
    logic [N_CH-1:0]       bypass  = '0;
    wire  [N_CH*DW-1:0]    dout;
    wire  [N_CH-1:0]       dout_valid;
    wire  [N_CH-1:0]       tap_err;

    int errors = 0;
    int checks = 0;

    // Reference model: per-channel history of accepted samples, newest first.
    sample_t            m_hist [N_CH][$];
    int                 m_fill [N_CH];
    int                 m_tapq [N_CH];
    bit                 m_byp  [N_CH];
    bit                 m_err  [N_CH];
    logic [N_CH*DW-1:0] exp_dout;
    logic [N_CH-1:0]    exp_valid;
    logic [N_CH-1:0]    exp_err;

    always #5 clk = ~clk;

    multi_tap_delay #(
        .N_CH  (N_CH),
        .DW    (DW),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .din        (din),
        .tap        (tap),
        .bypass     (bypass),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .tap_err    (tap_err)
    );

    task automatic set_tap(input int c, input int v);
        tap[c*TAP_W +: TAP_W] = TAP_W'(v);
    endtask

    task automatic set_din(input int c, input int v);
        din[c*DW +: DW] = DW'(v);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_hist[c].delete();
            for (int i = 0; i < DEPTH - 1; i++) m_hist[c].push_back(sample_t'(INIT_S));
            m_fill[c] = 0;
            m_tapq[c] = 0;
            m_byp[c]  = 1'b0;
            m_err[c]  = 1'b0;
        end
        exp_dout  = {N_CH{INIT_S}};
        exp_valid = '0;
        exp_err   = '0;
    endtask

    // Advance the model by one clk using the currently driven inputs, then step the DUT.
    task automatic tick();
        sample_t d;
        sample_t s;
        int      t;
        bit      v;
        for (int c = 0; c < N_CH; c++) begin
            d = din[c*DW +: DW];
            t = int'(tap[c*TAP_W +: TAP_W]);
            if (ce) begin
                v = m_byp[c] || (m_fill[c] >= m_tapq[c]);
                if (m_byp[c] || m_tapq[c] == 0) s = d;
                else                             s = m_hist[c][m_tapq[c] - 1];
`ifdef MTD_INVALID_ZERO_EN
                if (!v) s = '0;
`endif
                exp_dout[c*DW +: DW] = s;
                exp_valid[c] = v;
                m_hist[c].push_front(d);
                if (m_hist[c].size() > DEPTH - 1) void'(m_hist[c].pop_back());
                if (m_fill[c] < DEPTH) m_fill[c]++;
            end else begin
                exp_valid[c] = 1'b0;
            end
            if (t > DEPTH - 1) begin
                m_err[c]  = 1'b1;
                m_tapq[c] = DEPTH - 1;
            end else begin
                m_tapq[c] = t;
                if (err_clr) m_err[c] = 1'b0;
            end
            m_byp[c]   = bypass[c];
            exp_err[c] = m_err[c];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_assert();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    task automatic rst_release();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst_assert();
        checks++;
        if (dout !== {N_CH{INIT_S}}) begin
            errors++; $display("FAIL reset_dout got=%h exp=%h", dout, {N_CH{INIT_S}});
        end
        checks++;
        if (dout_valid !== '0) begin
            errors++; $display("FAIL reset_valid got=%b exp=0", dout_valid);
        end
        checks++;
        if (tap_err !== '0) begin
            errors++; $display("FAIL reset_tap_err got=%b exp=0", tap_err);
        end
        rst_release();
    endtask

    task automatic test_tap3();
        logic e;
        rst_assert(); rst_release();
        ce = 1'b0; bypass = '0; err_clr = 1'b0; tap = '0; din = '0;
        set_tap(0, 3);
        tick();
        for (int k = 1; k <= 10; k++) begin
            ce = 1'b1;
            set_din(0, k);
            for (int c = 1; c < N_CH; c++) set_din(c, int'($urandom));
            tick();
            e = (k >= 4);
            checks++;
            if (dout_valid[0] !== e) begin
                errors++; $display("FAIL tap3_valid k=%0d got=%b exp=%b", k, dout_valid[0], e);
            end
            if (k >= 4) begin
                checks++;
                if (dout[DW-1:0] !== DW'(k - 3)) begin
                    errors++; $display("FAIL tap3_dout k=%0d got=%0d exp=%0d", k, dout[DW-1:0], k - 3);
                end
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid) begin
                errors++; $display("FAIL tap3_model got=%h/%b exp=%h/%b", dout, dout_valid, exp_dout, exp_valid);
            end
        end
    endtask

    task automatic test_bypass();
        sample_t d;
        rst_assert(); rst_release();
        tap = '0; set_tap(0, 2); set_tap(2, 5); set_tap(3, 1);
        bypass = 4'b0010; err_clr = 1'b0; ce = 1'b1;
        for (int k = 0; k < 6; k++) begin
            d = (k == 0) ? sample_t'(DW'(-4096)) : sample_t'($urandom);
            for (int c = 0; c < N_CH; c++) set_din(c, int'($urandom));
            din[DW +: DW] = d;
            tick();
            checks++;
            if (dout[DW +: DW] !== d || dout_valid[1] !== 1'b1) begin
                errors++; $display("FAIL bypass_ch1 k=%0d got=%h/%b exp=%h/1", k, dout[DW +: DW], dout_valid[1], d);
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid) begin
                errors++; $display("FAIL bypass_model got=%h/%b exp=%h/%b", dout, dout_valid, exp_dout, exp_valid);
            end
        end
        bypass = '0;
    endtask

    task automatic test_ce_toggle();
        logic [N_CH*DW-1:0] prev;
        logic               e;
        int                 n;
        rst_assert(); rst_release();
        bypass = '0; err_clr = 1'b0; ce = 1'b0;
        for (int c = 0; c < N_CH; c++) set_tap(c, 2);
        tick();
        prev = dout;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            ce = (i % 2 == 0);
            if (ce) n++;
            for (int c = 0; c < N_CH; c++) set_din(c, n);
            tick();
            if (!ce) begin
                checks++;
                if (dout_valid !== '0) begin
                    errors++; $display("FAIL ce_low_valid i=%0d got=%b exp=0", i, dout_valid);
                end
                checks++;
                if (dout !== prev) begin
                    errors++; $display("FAIL ce_low_hold i=%0d got=%h exp=%h", i, dout, prev);
                end
            end else begin
                e = (n >= 3);
                checks++;
                if (dout_valid[0] !== e) begin
                    errors++; $display("FAIL ce_valid n=%0d got=%b exp=%b", n, dout_valid[0], e);
                end
                if (e) begin
                    checks++;
                    if (dout[DW-1:0] !== DW'(n - 2)) begin
                        errors++; $display("FAIL ce_delay n=%0d got=%0d exp=%0d", n, dout[DW-1:0], n - 2);
                    end
                end
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid) begin
                errors++; $display("FAIL ce_model got=%h/%b exp=%h/%b", dout, dout_valid, exp_dout, exp_valid);
            end
            prev = dout;
        end
    endtask

    task automatic test_tap_err();
        rst_assert(); rst_release();
        bypass = '0; err_clr = 1'b0; tap = '0;
        set_tap(2, 30);
        for (int n = 1; n <= 30; n++) begin
            ce = 1'b1;
            for (int c = 0; c < N_CH; c++) set_din(c, n);
            tick();
            if (n == 1) begin
                checks++;
                if (tap_err !== 4'b0100) begin
                    errors++; $display("FAIL tap_err_set got=%b exp=0100", tap_err);
                end
            end
            if (n >= 24) begin
                checks++;
                if (dout[2*DW +: DW] !== DW'(n - 23) || dout_valid[2] !== 1'b1) begin
                    errors++; $display("FAIL tap_clamp n=%0d got=%0d/%b exp=%0d/1", n, dout[2*DW +: DW], dout_valid[2], n - 23);
                end
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid || tap_err !== exp_err) begin
                errors++; $display("FAIL tap_err_model got=%h/%b/%b exp=%h/%b/%b", dout, dout_valid, tap_err, exp_dout, exp_valid, exp_err);
            end
        end
        ce = 1'b0;
        err_clr = 1'b1; tick();
        checks++;
        if (tap_err[2] !== 1'b1) begin errors++; $display("FAIL clr_while_over got=%b exp=1", tap_err[2]); end
        err_clr = 1'b0; set_tap(2, 5); tick();
        checks++;
        if (tap_err[2] !== 1'b1) begin errors++; $display("FAIL sticky got=%b exp=1", tap_err[2]); end
        err_clr = 1'b1; tick();
        checks++;
        if (tap_err[2] !== 1'b0) begin errors++; $display("FAIL clr got=%b exp=0", tap_err[2]); end
        set_tap(2, 30); tick();
        checks++;
        if (tap_err[2] !== 1'b1) begin errors++; $display("FAIL set_beats_clr got=%b exp=1", tap_err[2]); end
        set_tap(2, 5); tick();
        checks++;
        if (tap_err !== exp_err || tap_err[2] !== 1'b0) begin
            errors++; $display("FAIL clr_again got=%b exp=%b", tap_err, exp_err);
        end
        err_clr = 1'b0;
    endtask

    task automatic test_tap_change();
        rst_assert(); rst_release();
        bypass = '0; err_clr = 1'b0; tap = '0; ce = 1'b0;
        set_tap(0, 4);
        tick();
        for (int n = 1; n <= 30; n++) begin
            ce = 1'b1;
            set_tap(0, (n <= 10) ? 4 : (n <= 21) ? 20 : 2);
            for (int c = 0; c < N_CH; c++) set_din(c, n);
            tick();
            if (n >= 12 && n <= 20) begin
                checks++;
                if (dout_valid[0] !== 1'b0) begin
                    errors++; $display("FAIL tap_grow_valid n=%0d got=%b exp=0", n, dout_valid[0]);
                end
            end else if (n >= 21 && n <= 22) begin
                checks++;
                if (dout_valid[0] !== 1'b1 || dout[DW-1:0] !== DW'(n - 20)) begin
                    errors++; $display("FAIL tap20 n=%0d got=%0d/%b exp=%0d/1", n, dout[DW-1:0], dout_valid[0], n - 20);
                end
            end else if (n >= 23) begin
                checks++;
                if (dout_valid[0] !== 1'b1 || $isunknown(dout) || dout[DW-1:0] !== DW'(n - 2)) begin
                    errors++; $display("FAIL tap_shrink n=%0d got=%0d/%b exp=%0d/1", n, dout[DW-1:0], dout_valid[0], n - 2);
                end
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid) begin
                errors++; $display("FAIL tap_change_model got=%h/%b exp=%h/%b", dout, dout_valid, exp_dout, exp_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [DW-1:0] e0;
`ifdef MTD_INVALID_ZERO_EN
        e0 = '0;
`else
        e0 = INIT_S;
`endif
        bypass = '0; err_clr = 1'b0;
        for (int c = 0; c < N_CH; c++) set_tap(c, 6);
        for (int k = 0; k < 15; k++) begin
            ce = 1'b1;
            for (int c = 0; c < N_CH; c++) set_din(c, int'($urandom));
            tick();
        end
        rst_assert();
        checks++;
        if (dout !== {N_CH{INIT_S}} || dout_valid !== '0) begin
            errors++; $display("FAIL midrst_async got=%h/%b exp=%h/0", dout, dout_valid, {N_CH{INIT_S}});
        end
        rst_release();
        ce = 1'b0;
        tick();
        for (int k = 1; k <= 7; k++) begin
            ce = 1'b1;
            for (int c = 0; c < N_CH; c++) set_din(c, 1000 + k);
            tick();
            if (k <= 6) begin
                checks++;
                if (dout !== {N_CH{e0}} || dout_valid !== '0) begin
                    errors++; $display("FAIL midrst_refill k=%0d got=%h/%b exp=%h/0", k, dout, dout_valid, {N_CH{e0}});
                end
            end else begin
                checks++;
                if (dout !== {N_CH{DW'(1001)}} || dout_valid !== '1) begin
                    errors++; $display("FAIL midrst_first got=%h/%b exp=%h/f", dout, dout_valid, {N_CH{DW'(1001)}});
                end
            end
            checks++;
            if (dout !== exp_dout || dout_valid !== exp_valid) begin
                errors++; $display("FAIL midrst_model got=%h/%b exp=%h/%b", dout, dout_valid, exp_dout, exp_valid);
            end
        end
    endtask

    task automatic test_random();
        rst_assert(); rst_release();
        for (int c = 0; c < N_CH; c++) set_tap(c, int'($urandom_range(0, 31)));
        for (int k = 0; k < 400; k++) begin
            ce      = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < N_CH; c++) begin
                set_din(c, int'($urandom));
                if ($urandom_range(0, 15) == 0) set_tap(c, int'($urandom_range(0, 31)));
                if ($urandom_range(0, 19) == 0) bypass[c] = ~bypass[c];
            end
            tick();
            checks++;
            if (dout !== exp_dout) begin
                errors++; $display("FAIL rand_dout k=%0d got=%h exp=%h", k, dout, exp_dout);
            end
            checks++;
            if (dout_valid !== exp_valid) begin
                errors++; $display("FAIL rand_valid k=%0d got=%b exp=%b", k, dout_valid, exp_valid);
            end
            checks++;
            if (tap_err !== exp_err) begin
                errors++; $display("FAIL rand_tap_err k=%0d got=%b exp=%b", k, tap_err, exp_err);
            end
        end
        err_clr = 1'b0;
        bypass  = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tap3();
        test_bypass();
        test_ce_toggle();
        test_tap_err();
        test_tap_change();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
